// File: rtl/alu_pkg.sv
// Shared widths, vector-space constants and sweep FSM state encoding for the
// 3-bit ALU self-test driver.
package alu_pkg;

    localparam int A_W     = 3;
    localparam int B_W     = 3;
    localparam int CTRL_W  = 3;
    localparam int RES_W   = 6;
    localparam int VEC_W   = A_W + B_W + CTRL_W;
    localparam int NUM_VEC = 1 << VEC_W;
    localparam int SIG_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/alu_sig_accum.sv
// Rotating-XOR signature register: clear on sweep start, fold one ALU result
// per sample.
module alu_sig_accum #(
    parameter int SIG_W = alu_pkg::SIG_W,
    parameter int RES_W = alu_pkg::RES_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             fold,
    input  logic [RES_W-1:0] res_in,
    output logic [SIG_W-1:0] signature
);

    // Rotate left by one, then XOR in the zero-extended result.
    function automatic logic [SIG_W-1:0] rot_fold(input logic [SIG_W-1:0] sig,
                                                  input logic [RES_W-1:0] res);
        return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(res);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= '0;
        end else if (clr) begin
            signature <= '0;
        end else if (fold) begin
            signature <= rot_fold(signature, res_in);
        end
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Exhaustive {ctrl, B, A} operand sweep for the 3-bit ALU with signature
// capture. Define ALU_SWEEP_STEP_EN to add a manual single-step input.
module alu_sweep_driver #(
    parameter int A_W    = alu_pkg::A_W,
    parameter int B_W    = alu_pkg::B_W,
    parameter int CTRL_W = alu_pkg::CTRL_W,
    parameter int RES_W  = alu_pkg::RES_W,
    parameter int SETTLE = 2,
    parameter int SIG_W  = alu_pkg::SIG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
`ifdef ALU_SWEEP_STEP_EN
    input  logic                      step,
`endif
    output logic [A_W-1:0]            op_a,
    output logic [B_W-1:0]            op_b,
    output logic [CTRL_W-1:0]         op_ctrl,
    input  logic [RES_W-1:0]          res_in,
    output logic                      busy,
    output logic                      done,
    output logic [SIG_W-1:0]          signature,
    output logic [A_W+B_W+CTRL_W-1:0] vec_idx
);

    import alu_pkg::*;

    localparam int                VEC_W    = A_W + B_W + CTRL_W;
    localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE - 1);

    sweep_state_t     state;
    logic [CNT_W-1:0] settle_cnt;
    logic             sample_go;
    logic             accept;
    logic             fold_en;

`ifdef ALU_SWEEP_STEP_EN
    assign sample_go = step;
`else
    assign sample_go = 1'b1;
`endif

    // Abort beats start in IDLE; in DONE abort is inert so start always wins.
    assign accept  = ((state == IDLE) && start && !abort) ||
                     ((state == DONE) && start);
    assign fold_en = (state == SAMPLE) && !abort && sample_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= WAIT;
                        settle_cnt <= CNT_LOAD;
                        vec_idx    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state   <= IDLE;
                        vec_idx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state   <= IDLE;
                        vec_idx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else if (sample_go) begin
                        if (vec_idx == '1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            settle_cnt <= CNT_LOAD;
                            vec_idx    <= vec_idx + VEC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand pins are straight slices of the vector register.
    assign op_a    = vec_idx[A_W-1:0];
    assign op_b    = vec_idx[A_W +: B_W];
    assign op_ctrl = vec_idx[A_W+B_W +: CTRL_W];

    alu_sig_accum #(
        .SIG_W (SIG_W),
        .RES_W (RES_W)
    ) u_sig_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .fold      (fold_en),
        .res_in    (res_in),
        .signature (signature)
    );

endmodule
